// File: rtl/word_echo_fifo.sv
// Assembles UART bytes into words, buffers them in a DEPTH-entry FIFO and re-serialises them to uart_tx.
// Define WORD_ECHO_CHECKSUM_EN to append an XOR checksum byte after each word.
module word_echo_fifo #(
  parameter int BYTES_PER_WORD = 4,
  parameter int DEPTH          = 4,
  parameter int MSB_FIRST      = 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [7:0]                  byte_in,
  input  logic                        rx_done,
  input  logic                        byte_sent,
  output logic [7:0]                  byte_out,
  output logic                        uart_send,
  output logic [8*BYTES_PER_WORD-1:0] word_out,
  output logic                        word_done,
  output logic                        send_done,
  output logic [$clog2(DEPTH):0]      fifo_count,
  output logic                        overflow,
  output logic                        idle
);
  localparam int W  = 8 * BYTES_PER_WORD;
  localparam int IW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BYTES_PER_WORD - 1);

`ifdef WORD_ECHO_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, NEXT, CSUM} state_t;
`else
  typedef enum logic [2:0] {IDLE, LOAD, SEND, WAIT, NEXT} state_t;
`endif

  state_t          state, state_n;
  logic            rx_prev, sent_prev, rx_ev, sent_ev;
  logic [IW-1:0]   rx_idx, tx_idx;
  logic [W-1:0]    rx_word, rx_next, tx_word;
  logic [W-1:0]    mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic            rx_last, full, push, pop;
  logic            tx_adv, word_end;
  logic [7:0]      tx_byte;
  int              rx_slot, tx_slot;
`ifdef WORD_ECHO_CHECKSUM_EN
  logic            csum_phase;
  logic [7:0]      csum;
`endif

  assign rx_ev   = rx_done & ~rx_prev;
  assign sent_ev = byte_sent & ~sent_prev;
  assign rx_last = rx_ev && (rx_idx == LAST_IDX);
  assign full    = (fifo_count == CW'(DEPTH));
  assign push    = rx_last && !full;
  assign pop     = (state == LOAD) && (fifo_count != '0);
  assign idle    = (fifo_count == '0) && (state == IDLE) && (rx_idx == '0);

  // Slot order is mirrored between RX and TX so a word round-trips unchanged.
  always_comb begin
    rx_slot = (MSB_FIRST != 0) ? BYTES_PER_WORD - 1 - int'(rx_idx) : int'(rx_idx);
    tx_slot = (MSB_FIRST != 0) ? BYTES_PER_WORD - 1 - int'(tx_idx) : int'(tx_idx);
    rx_next = rx_word;
    rx_next[8*rx_slot +: 8] = byte_in;
    tx_byte = tx_word[8*tx_slot +: 8];
  end

`ifdef WORD_ECHO_CHECKSUM_EN
  always_comb begin
    csum = '0;
    for (int i = 0; i < BYTES_PER_WORD; i++) csum ^= tx_word[8*i +: 8];
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_prev    <= 1'b0;
      sent_prev  <= 1'b0;
      rx_idx     <= '0;
      rx_word    <= '0;
      word_out   <= '0;
      word_done  <= 1'b0;
      overflow   <= 1'b0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      rx_prev   <= rx_done;
      sent_prev <= byte_sent;
      word_done <= rx_last;
      if (rx_ev) begin
        rx_word <= rx_next;
        rx_idx  <= rx_last ? '0 : rx_idx + IW'(1);
      end
      if (rx_last) word_out <= rx_next;
      if (rx_last && full) overflow <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= rx_next;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n  = state;
    tx_adv   = 1'b0;
    word_end = 1'b0;
    case (state)
      IDLE: if (fifo_count != '0) state_n = LOAD;
      LOAD: state_n = SEND;
      SEND: state_n = WAIT;
      WAIT: if (sent_ev) state_n = NEXT;
      NEXT: begin
`ifdef WORD_ECHO_CHECKSUM_EN
        if (csum_phase) word_end = 1'b1;
        else if (tx_idx != LAST_IDX) begin
          tx_adv  = 1'b1;
          state_n = SEND;
        end else state_n = CSUM;
`else
        if (tx_idx != LAST_IDX) begin
          tx_adv  = 1'b1;
          state_n = SEND;
        end else word_end = 1'b1;
`endif
        if (word_end) state_n = (fifo_count != '0) ? LOAD : IDLE;
      end
`ifdef WORD_ECHO_CHECKSUM_EN
      CSUM: state_n = SEND;
`endif
      default: state_n = IDLE;
    endcase
  end

  // uart_send/byte_out are registered off SEND, landing one cycle later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tx_word    <= '0;
      tx_idx     <= '0;
      byte_out   <= '0;
      uart_send  <= 1'b0;
      send_done  <= 1'b0;
`ifdef WORD_ECHO_CHECKSUM_EN
      csum_phase <= 1'b0;
`endif
    end else begin
      uart_send <= (state == SEND);
      send_done <= word_end;
      if (state == LOAD) begin
        tx_word <= mem[rd_ptr];
        tx_idx  <= '0;
`ifdef WORD_ECHO_CHECKSUM_EN
        csum_phase <= 1'b0;
`endif
      end
      if (tx_adv) tx_idx <= tx_idx + IW'(1);
`ifdef WORD_ECHO_CHECKSUM_EN
      if (state == CSUM) csum_phase <= 1'b1;
      if (state == SEND) byte_out <= csum_phase ? csum : tx_byte;
`else
      if (state == SEND) byte_out <= tx_byte;
`endif
    end
  end
endmodule
